// File: rtl/unpack_pkg.sv
// Shared types and constants for the packet-source arbiter in front of the
// 32-to-7 unpacker.
package unpack_pkg;

    // Arbiter control state: waiting for a sop candidate, or streaming one packet.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Default beat width handed to the unpacker.
    localparam int UNPACK_DATA_W = 32;

    // Width of one unpacked output symbol produced by the downstream unpacker.
    localparam int SYM_W = 7;

endpackage

// File: rtl/unpack_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins. Returns both the winner index and a one-hot grant.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scan from the farthest offset down to ptr so the nearest requester is kept last.
    always_comb begin
        int pos;
        any = 1'b0;
        idx = '0;
        pos = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NUM_CH;
            if (req[pos]) begin
                any = 1'b1;
                idx = IDX_W'(pos);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign grant[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/unpack_arbiter.sv
// Round-robin packet arbiter feeding one shared unpacker. A packet owner is
// chosen in an idle cycle from sources showing sop; the owner's beats are then
// passed straight through (no buffering) until its eop is accepted.
module unpack_arbiter
    import unpack_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = UNPACK_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          s_valid,
    input  logic [NUM_CH*DATA_W-1:0]   s_data,
    input  logic [NUM_CH-1:0]          s_sop,
    input  logic [NUM_CH-1:0]          s_eop,
    output logic [NUM_CH-1:0]          s_ready,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_sop,
    output logic                       m_eop,
    input  logic                       m_ready,
    output logic [$clog2(NUM_CH)-1:0]  m_ch,
    output logic [NUM_CH-1:0]          err_nosop,
    output logic [NUM_CH-1:0]          err_sop
);

    localparam int IDX_W = $clog2(NUM_CH);

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    g_reg, g_next;
    logic [NUM_CH-1:0]   g_oh_reg, g_oh_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic                first_reg, first_next;
    logic [NUM_CH-1:0]   err_nosop_reg, err_nosop_next;
    logic [NUM_CH-1:0]   err_sop_reg, err_sop_next;

    logic [DATA_W-1:0]   data_arr [NUM_CH];
    logic [NUM_CH-1:0]   cand_vec;
    logic [NUM_CH-1:0]   drop_vec;
    logic [NUM_CH-1:0]   arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                sel_valid, sel_sop, sel_eop;
    logic [DATA_W-1:0]   sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_split
            assign data_arr[gi] = s_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // A beat shown with sop is a new-packet candidate; one without sop while idle is stray.
    assign cand_vec = s_valid & s_sop;
    assign drop_vec = s_valid & ~s_sop;

    assign sel_valid = s_valid[g_reg];
    assign sel_sop   = s_sop[g_reg];
    assign sel_eop   = s_eop[g_reg];
    assign sel_data  = data_arr[g_reg];

    assign m_ch      = g_reg;
    assign err_nosop = err_nosop_reg;
    assign err_sop   = err_sop_reg;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req   (cand_vec),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Next-state logic plus the combinational handshake routing.
    always_comb begin
        state_next     = state_reg;
        g_next         = g_reg;
        g_oh_next      = g_oh_reg;
        rr_ptr_next    = rr_ptr_reg;
        first_next     = first_reg;
        err_nosop_next = err_nosop_reg;
        err_sop_next   = err_sop_reg;
        s_ready        = '0;
        m_valid        = 1'b0;
        m_data         = '0;
        m_sop          = 1'b0;
        m_eop          = 1'b0;

        case (state_reg)
            IDLE: begin
                // Stray mid-packet beats are swallowed so a broken source cannot stall.
                s_ready        = drop_vec;
                err_nosop_next = err_nosop_reg | drop_vec;
                if (arb_any) begin
                    state_next = XFER;
                    g_next     = arb_idx;
                    g_oh_next  = arb_grant;
                    first_next = 1'b1;
                end
            end
            XFER: begin
                m_valid = sel_valid;
                if (sel_valid) begin
                    m_data = sel_data;
                    m_sop  = sel_sop;
                    m_eop  = sel_eop;
                end
                s_ready = g_oh_reg & {NUM_CH{m_ready}};
                if (sel_valid && m_ready) begin
                    first_next = 1'b0;
                    // The opening beat legitimately carries sop; any later one is a framing error.
                    if (sel_sop && !first_reg) begin
                        err_sop_next = err_sop_reg | g_oh_reg;
                    end
                    if (sel_eop) begin
                        state_next  = IDLE;
                        rr_ptr_next = (g_reg == IDX_W'(NUM_CH - 1)) ? '0 : g_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Nothing may transfer while the shared reset is held.
        if (rst) begin
            s_ready = '0;
            m_valid = 1'b0;
            m_data  = '0;
            m_sop   = 1'b0;
            m_eop   = 1'b0;
        end
    end

    // State, ownership, pointer and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            g_reg         <= '0;
            g_oh_reg      <= '0;
            rr_ptr_reg    <= '0;
            first_reg     <= 1'b0;
            err_nosop_reg <= '0;
            err_sop_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            g_reg         <= g_next;
            g_oh_reg      <= g_oh_next;
            rr_ptr_reg    <= rr_ptr_next;
            first_reg     <= first_next;
            err_nosop_reg <= err_nosop_next;
            err_sop_reg   <= err_sop_next;
        end
    end

endmodule

// File: doc/unpack_arbiter.md
UNPACK_ARBITER -- requirements
Module: unpack_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of packet sources sharing one 32-to-7 unpacker; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: beat width passed to the unpacker.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_valid  in  NUM_CH  per-source beat valid.
REQ-006 s_data  in  NUM_CH*DATA_W  per-source beat data; source i in bits [i*DATA_W +: DATA_W].
REQ-007 s_sop / s_eop  in  NUM_CH each  per-source start/end-of-packet markers.
REQ-008 s_ready  out  NUM_CH  per-source accept; a beat transfers when s_valid[i] & s_ready[i].
REQ-009 m_valid, m_data[DATA_W], m_sop, m_eop  out  beat to the unpacker.
REQ-010 m_ready  in  1  unpacker accept (its ready_out); a beat transfers when m_valid & m_ready.
REQ-011 m_ch  out  clog2(NUM_CH)  source index of the current packet, stable from grant until final eop accepted.
REQ-012 err_nosop  out  NUM_CH  sticky: source presented a beat without sop while not granted.
REQ-013 err_sop  out  NUM_CH  sticky: source presented sop in mid-packet.

Function
REQ-014 FSM states SHALL be IDLE and XFER, encoded in a 1-bit state register.
REQ-015 IDLE: candidates are sources with s_valid & s_sop; round-robin from pointer rr_ptr (rr_ptr first, then rr_ptr+1, ... wrapping mod NUM_CH).
REQ-016 IDLE with >=1 candidate: next cycle state=XFER, grant register g=winner, m_ch=winner; no beat transfers in the arbitration cycle.
REQ-017 XFER: m_valid=s_valid[g], m_data/m_sop/m_eop=source g fields, s_ready[g]=m_ready; all other s_ready=0 (combinational pass-through, zero added latency).
REQ-018 XFER: beat accepted with m_eop=1 -> next cycle IDLE, rr_ptr=(g+1) mod NUM_CH.
REQ-019 Single-beat packet (sop and eop on the same beat) SHALL follow REQ-016..018: one arbitration cycle, one transfer cycle.
REQ-020 Back-to-back: after eop, minimum one IDLE cycle before the next grant; the same source SHALL be regranted only when no other candidate exists.
REQ-021 IDLE: source with s_valid=1, s_sop=0 SHALL have its beat dropped (s_ready[i]=1 that cycle) and err_nosop[i] set.
REQ-022 IDLE: source with s_valid=1, s_sop=1 that does not win SHALL see s_ready[i]=0.
REQ-023 XFER: accepted beat from g with s_sop=1 SHALL pass through unchanged and set err_sop[g].
REQ-024 m_valid SHALL be 0 in IDLE; m_sop/m_eop/m_data SHALL be 0 whenever m_valid=0.
REQ-025 m_valid=1 with m_ready=0 SHALL hold; the source is responsible for holding data (no internal buffering).

Reset
REQ-026 rst SHALL force state=IDLE, g=0, m_ch=0, rr_ptr=0, err_nosop=0, err_sop=0, m_valid=0, s_ready=0 on the next edge.
REQ-027 rst mid-packet SHALL abandon the packet with no eop emitted; the unpacker shares rst and is reset in the same cycle.
REQ-028 Error flags SHALL clear only on rst.

Structure
REQ-029 Package unpack_pkg SHALL hold the state enum (IDLE, XFER), DATA_W default, and the 7-bit unpacked symbol width constant.
REQ-030 Sub-module rr_arbiter (request vector, pointer -> one-hot grant plus index, purely combinational) SHALL implement REQ-015.

Verification
REQ-031 Sources 0 and 2 both sop at cycle 1, m_ready=1 -> grant 0 (m_ch=0), 3-beat packet, IDLE, then grant 2; rr_ptr=1 then 3.
REQ-032 All 4 sources continuously sending 1-beat packets -> grant order 0,1,2,3,0; transfer every second cycle.
REQ-033 Source 1 granted, m_ready low 5 cycles mid-packet -> m_valid held, m_data unchanged, s_ready[1]=0 throughout.
REQ-034 Source 3 valid with sop=0 in IDLE -> beat dropped, err_nosop=4'b1000, no grant.
REQ-035 Source 0 sends sop on its 2nd beat -> beat forwarded, err_sop[0]=1; rst asserted on beat 3 -> m_valid=0, all flags and rr_ptr cleared next cycle.
